nn_layer_sequencer: RTL and testbench

Control FSM that walks a configured fully-connected network (up to 5 layers) layer by layer, neuron by neuron, and input by input. It issues one multiply-accumulate request per weight to the shared CORDIC MAC unit and one activation request per neuron to the CORDIC activation unit. It generates weight and ping-pong activation-buffer addresses. It sits inside `final_destination` between the top-level configuration inputs and the CORDIC datapath.

---
 rtl/nn_layer_sequencer_pkg.sv | 41 ++++
 rtl/nn_layer_sequencer_if.sv | 35 +++
 rtl/nn_layer_sequencer_cfg_mux.sv | 62 ++++++
 rtl/nn_layer_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// nn_seq_pkg
// Shared types and constants for the fully-connected layer sequencer:
//   - seq_state_e : sequencer FSM states
//   - CNT_W       : width of layer / neuron / input counters
//   - MAX_LAYERS  : deepest network supported, input layer included
//   - WADDR_W     : weight-memory address width
//   - AF_*        : activation codes forwarded to the CORDIC activation unit
//   - sat_layers  : clamps a requested layer count to MAX_LAYERS
// -----------------------------------------------------------------------------
package nn_seq_pkg;

    localparam int MAX_LAYERS = 5;
    localparam int CNT_W      = 6;
    localparam int WADDR_W    = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        ACT  = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    localparam logic [1:0] AF_LINEAR  = 2'd0;
    localparam logic [1:0] AF_RELU    = 2'd1;
    localparam logic [1:0] AF_SIGMOID = 2'd2;
    localparam logic [1:0] AF_TANH    = 2'd3;

    // Requests deeper than the hardware supports run as MAX_LAYERS layers.
    function automatic logic [CNT_W-1:0] sat_layers(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] r;
        if (n > CNT_W'(MAX_LAYERS)) begin
            r = CNT_W'(MAX_LAYERS);
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer_if
// Request bus between the layer sequencer and the CORDIC datapath.
//   MAC channel : mac_valid/mac_ready, mac_first, mac_last, w_addr, x_addr
//   ACT channel : act_valid/act_ready, act_sel, y_addr
// master = sequencer side, slave = datapath side.
// x_addr / y_addr are {bank, index}, hence CNT_W+1 bits.
// -----------------------------------------------------------------------------
interface nn_layer_sequencer_if #(
    parameter int WADDR_W = 10,
    parameter int CNT_W   = 6
);
    logic               mac_valid;
    logic               mac_ready;
    logic               mac_first;
    logic               mac_last;
    logic [WADDR_W-1:0] w_addr;
    logic [CNT_W:0]     x_addr;
    logic               act_valid;
    logic               act_ready;
    logic [1:0]         act_sel;
    logic [CNT_W:0]     y_addr;

    modport master (
        output mac_valid, mac_first, mac_last, w_addr, x_addr,
        output act_valid, act_sel, y_addr,
        input  mac_ready, act_ready
    );

    modport slave (
        input  mac_valid, mac_first, mac_last, w_addr, x_addr,
        input  act_valid, act_sel, y_addr,
        output mac_ready, act_ready
    );
endinterface

// File: rtl/nn_layer_sequencer_cfg_mux.sv
// -----------------------------------------------------------------------------
// nn_layer_cfg_mux
// Combinational selection of per-layer configuration by layer index k.
//   nl_cfg[0..4]  : latched neuron counts nl1..nl5
//   afl_cfg[0..4] : latched activation codes afl1..afl5
//   layer         : current layer index k (1-based)
//   nl_cur        : nl_k     (neurons in this layer)
//   nl_prev       : nl_{k-1} (fan-in of each neuron in this layer)
//   af_cur        : afl_k
// -----------------------------------------------------------------------------
module nn_layer_cfg_mux #(
    parameter int MAX_LAYERS = 5,
    parameter int CNT_W      = 6
) (
    input  logic [CNT_W-1:0] nl_cfg  [MAX_LAYERS],
    input  logic [1:0]       afl_cfg [MAX_LAYERS],
    input  logic [CNT_W-1:0] layer,
    output logic [CNT_W-1:0] nl_cur,
    output logic [CNT_W-1:0] nl_prev,
    output logic [1:0]       af_cur
);
    import nn_seq_pkg::*;

    // Per-layer lookup; index 1 (input layer) has no predecessor and is never computed.
    always_comb begin
        nl_cur  = '0;
        nl_prev = '0;
        af_cur  = AF_LINEAR;
        case (layer)
            6'd1: begin
                nl_cur  = nl_cfg[0];
                nl_prev = '0;
                af_cur  = afl_cfg[0];
            end
            6'd2: begin
                nl_cur  = nl_cfg[1];
                nl_prev = nl_cfg[0];
                af_cur  = afl_cfg[1];
            end
            6'd3: begin
                nl_cur  = nl_cfg[2];
                nl_prev = nl_cfg[1];
                af_cur  = afl_cfg[2];
            end
            6'd4: begin
                nl_cur  = nl_cfg[3];
                nl_prev = nl_cfg[2];
                af_cur  = afl_cfg[3];
            end
            6'd5: begin
                nl_cur  = nl_cfg[4];
                nl_prev = nl_cfg[3];
                af_cur  = afl_cfg[4];
            end
            default: begin
                nl_cur  = '0;
                nl_prev = '0;
                af_cur  = AF_LINEAR;
            end
        endcase
    end
endmodule

// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
// Walks a configured fully-connected network layer by layer, neuron by neuron
// and input by input, issuing one MAC request per weight and one activation
// request per neuron. Activations ping-pong between two banks: layer k reads
// bank b and writes bank ~b; the bank flips when a layer completes.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start             : begin inference (only looked at in IDLE)
//   no_layers         : layer count incl. input layer (clamped to MAX_LAYERS)
//   nl1..nl5          : neurons per layer, nl1 = input width
//   afl1..afl5        : activation code per layer (afl1 unused)
//   bus (master)      : MAC / ACT request channels, see nn_layer_sequencer_if
//   busy, done, err   : status; err holds until the next accepted start
// The 5 nl/afl ports fix the supported depth; MAX_LAYERS must stay 5.
// -----------------------------------------------------------------------------
module nn_layer_sequencer #(
    parameter int MAX_LAYERS = nn_seq_pkg::MAX_LAYERS,
    parameter int CNT_W      = nn_seq_pkg::CNT_W,
    parameter int WADDR_W    = nn_seq_pkg::WADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] no_layers,
    input  logic [CNT_W-1:0] nl1,
    input  logic [CNT_W-1:0] nl2,
    input  logic [CNT_W-1:0] nl3,
    input  logic [CNT_W-1:0] nl4,
    input  logic [CNT_W-1:0] nl5,
    input  logic [1:0]       afl1,
    input  logic [1:0]       afl2,
    input  logic [1:0]       afl3,
    input  logic [1:0]       afl4,
    input  logic [1:0]       afl5,
    nn_layer_sequencer_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import nn_seq_pkg::*;

    seq_state_e         state_r;
    logic [CNT_W-1:0]   no_layers_r;
    logic [CNT_W-1:0]   nl_r  [MAX_LAYERS];
    logic [1:0]         afl_r [MAX_LAYERS];
    logic [CNT_W-1:0]   layer_r;
    logic [CNT_W-1:0]   neuron_r;
    logic [CNT_W-1:0]   term_r;
    logic               bank_r;

    logic               mac_valid_r;
    logic               mac_first_r;
    logic               mac_last_r;
    logic [WADDR_W-1:0] w_addr_r;
    logic [CNT_W:0]     x_addr_r;
    logic               act_valid_r;
    logic [1:0]         act_sel_r;
    logic [CNT_W:0]     y_addr_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic [CNT_W-1:0]   nl_cur_s;
    logic [CNT_W-1:0]   fan_in_s;
    logic [1:0]         af_cur_s;
    logic               cfg_ok_s;

    nn_layer_cfg_mux #(
        .MAX_LAYERS (MAX_LAYERS),
        .CNT_W      (CNT_W)
    ) u_cfg_mux (
        .nl_cfg  (nl_r),
        .afl_cfg (afl_r),
        .layer   (layer_r),
        .nl_cur  (nl_cur_s),
        .nl_prev (fan_in_s),
        .af_cur  (af_cur_s)
    );

    // Latched-config sanity: at least one compute layer and no empty layer in use.
    always_comb begin
        cfg_ok_s = (no_layers_r >= CNT_W'(2));
        for (int j = 0; j < MAX_LAYERS; j++) begin
            if ((CNT_W'(j) < no_layers_r) && (nl_r[j] == '0)) begin
                cfg_ok_s = 1'b0;
            end else begin
                cfg_ok_s = cfg_ok_s;
            end
        end
    end

    // Sequencer FSM: state, counters, latched configuration and every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            no_layers_r <= '0;
            for (int j = 0; j < MAX_LAYERS; j++) begin
                nl_r[j]  <= '0;
                afl_r[j] <= '0;
            end
            layer_r     <= '0;
            neuron_r    <= '0;
            term_r      <= '0;
            bank_r      <= 1'b0;
            mac_valid_r <= 1'b0;
            mac_first_r <= 1'b0;
            mac_last_r  <= 1'b0;
            w_addr_r    <= '0;
            x_addr_r    <= '0;
            act_valid_r <= 1'b0;
            act_sel_r   <= 2'd0;
            y_addr_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        no_layers_r <= sat_layers(no_layers);
                        nl_r[0]     <= nl1;
                        nl_r[1]     <= nl2;
                        nl_r[2]     <= nl3;
                        nl_r[3]     <= nl4;
                        nl_r[4]     <= nl5;
                        afl_r[0]    <= afl1;
                        afl_r[1]    <= afl2;
                        afl_r[2]    <= afl3;
                        afl_r[3]    <= afl4;
                        afl_r[4]    <= afl5;
                        // First compute layer is 2; the mux needs it already in LOAD.
                        layer_r     <= CNT_W'(2);
                        busy_r      <= 1'b1;
                        err_r       <= 1'b0;
                        state_r     <= LOAD;
                    end
                end
                LOAD: begin
                    neuron_r <= '0;
                    term_r   <= '0;
                    bank_r   <= 1'b0;
                    w_addr_r <= '0;
                    if (!cfg_ok_s) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        mac_valid_r <= 1'b1;
                        mac_first_r <= 1'b1;
                        mac_last_r  <= (fan_in_s == CNT_W'(1));
                        x_addr_r    <= {1'b0, {CNT_W{1'b0}}};
                        state_r     <= MAC;
                    end
                end
                MAC: begin
                    if (bus.mac_ready) begin
                        w_addr_r <= w_addr_r + WADDR_W'(1);
                        if (term_r == fan_in_s - CNT_W'(1)) begin
                            term_r      <= '0;
                            mac_valid_r <= 1'b0;
                            mac_first_r <= 1'b0;
                            mac_last_r  <= 1'b0;
                            act_valid_r <= 1'b1;
                            act_sel_r   <= af_cur_s;
                            y_addr_r    <= {~bank_r, neuron_r};
                            state_r     <= ACT;
                        end else begin
                            term_r      <= term_r + CNT_W'(1);
                            mac_first_r <= 1'b0;
                            mac_last_r  <= ((term_r + CNT_W'(1)) == (fan_in_s - CNT_W'(1)));
                            x_addr_r    <= {bank_r, term_r + CNT_W'(1)};
                        end
                    end
                end
                ACT: begin
                    if (bus.act_ready) begin
                        act_valid_r <= 1'b0;
                        if (neuron_r < nl_cur_s - CNT_W'(1)) begin
                            neuron_r    <= neuron_r + CNT_W'(1);
                            term_r      <= '0;
                            mac_valid_r <= 1'b1;
                            mac_first_r <= 1'b1;
                            mac_last_r  <= (fan_in_s == CNT_W'(1));
                            x_addr_r    <= {bank_r, {CNT_W{1'b0}}};
                            state_r     <= MAC;
                        end else if (layer_r < no_layers_r) begin
                            // Next layer's fan-in is this layer's width; reads the bank just written.
                            layer_r     <= layer_r + CNT_W'(1);
                            neuron_r    <= '0;
                            term_r      <= '0;
                            bank_r      <= ~bank_r;
                            mac_valid_r <= 1'b1;
                            mac_first_r <= 1'b1;
                            mac_last_r  <= (nl_cur_s == CNT_W'(1));
                            x_addr_r    <= {~bank_r, {CNT_W{1'b0}}};
                            state_r     <= MAC;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mac_valid_r <= 1'b0;
                    act_valid_r <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mac_valid = mac_valid_r;
    assign bus.mac_first = mac_first_r;
    assign bus.mac_last  = mac_last_r;
    assign bus.w_addr    = w_addr_r;
    assign bus.x_addr    = x_addr_r;
    assign bus.act_valid = act_valid_r;
    assign bus.act_sel   = act_sel_r;
    assign bus.y_addr    = y_addr_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_layer_sequencer
// Self-checking bench: a table of configurations plus randomized ones are run
// against a reference model that lists every expected MAC/ACT beat with nested
// loops over layers, neurons and inputs. Each cycle the bench compares the DUT
// outputs with the beat at the head of that list; hand sequences cover reset
// behaviour.
// -----------------------------------------------------------------------------
module tb_nn_layer_sequencer;
    import nn_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] no_layers, nl1, nl2, nl3, nl4, nl5;
    logic [1:0] afl1, afl2, afl3, afl4, afl5;
    logic       busy, done, err;

    nn_layer_sequencer_if #(.WADDR_W(10), .CNT_W(6)) bus ();

    nn_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .no_layers(no_layers),
        .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
        .afl1(afl1), .afl2(afl2), .afl3(afl3), .afl4(afl4), .afl5(afl5),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]      no_layers;
        logic [4:0][5:0] nl;
        logic [4:0][1:0] afl;
        logic [1:0]      mode;     // 0: readies high, 1: mac_ready every other cycle, 2: random
        logic            poke;     // re-assert start while busy
        logic            use_exp;
        logic [11:0]     exp_done;
        logic            exp_err;
    } vec_t;

    typedef struct packed {
        logic       is_act;
        logic [9:0] w;
        logic [6:0] addr;
        logic       first;
        logic       last;
        logic [1:0] sel;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc_g  = 0;
    int    m_sum;
    bit    m_err;
    vec_t  tbl[10];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle %0d got 0x%0h expected 0x%0h", name, cyc_g, got, want);
        end
    endtask

    function automatic vec_t mk(input int nlay, input int n1, input int n2, input int n3,
                                input int n4, input int n5, input int a2, input int a3,
                                input int a4, input int a5, input int mode, input int poke,
                                input int use_exp, input int exp_done, input int exp_err);
        vec_t v;
        v.no_layers = 6'(nlay);
        v.nl        = {6'(n5), 6'(n4), 6'(n3), 6'(n2), 6'(n1)};
        v.afl       = {2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'd0};
        v.mode      = 2'(mode);
        v.poke      = 1'(poke);
        v.use_exp   = 1'(use_exp);
        v.exp_done  = 12'(exp_done);
        v.exp_err   = 1'(exp_err);
        return v;
    endfunction

    // Reference: enumerate every beat the network needs, in issue order.
    task automatic build_model(input vec_t v);
        int L;
        int w;
        int bank;
        beat_t b;
        q.delete();
        L = (v.no_layers > 6'd5) ? 5 : int'(v.no_layers);
        m_err = (L < 2);
        for (int j = 0; j < L; j++) if (v.nl[j] == 6'd0) m_err = 1'b1;
        m_sum = 0;
        if (!m_err) begin
            w = 0;
            for (int k = 1; k < L; k++) begin
                bank = (k - 1) % 2;
                m_sum += int'(v.nl[k]) * (int'(v.nl[k-1]) + 1);
                for (int n = 0; n < int'(v.nl[k]); n++) begin
                    for (int i = 0; i < int'(v.nl[k-1]); i++) begin
                        b        = '0;
                        b.w      = 10'(w % 1024);
                        b.addr   = 7'(bank * 64 + i);
                        b.first  = (i == 0);
                        b.last   = (i == int'(v.nl[k-1]) - 1);
                        q.push_back(b);
                        w++;
                    end
                    b        = '0;
                    b.is_act = 1'b1;
                    b.sel    = v.afl[k];
                    b.addr   = 7'((1 - bank) * 64 + n);
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic set_cfg(input vec_t v);
        no_layers = v.no_layers;
        nl1 = v.nl[0]; nl2 = v.nl[1]; nl3 = v.nl[2]; nl4 = v.nl[3]; nl5 = v.nl[4];
        afl1 = v.afl[0]; afl2 = v.afl[1]; afl3 = v.afl[2]; afl4 = v.afl[3]; afl5 = v.afl[4];
    endtask

    task automatic scramble_cfg();
        no_layers = 6'($urandom); nl1 = 6'($urandom); nl2 = 6'($urandom);
        nl3 = 6'($urandom); nl4 = 6'($urandom); nl5 = 6'($urandom);
        afl1 = 2'($urandom); afl2 = 2'($urandom); afl3 = 2'($urandom);
        afl4 = 2'($urandom); afl5 = 2'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mac_valid"}, int'(bus.mac_valid), 0);
        chk({tag, ".mac_first"}, int'(bus.mac_first), 0);
        chk({tag, ".mac_last"},  int'(bus.mac_last), 0);
        chk({tag, ".w_addr"},    int'(bus.w_addr), 0);
        chk({tag, ".x_addr"},    int'(bus.x_addr), 0);
        chk({tag, ".act_valid"}, int'(bus.act_valid), 0);
        chk({tag, ".act_sel"},   int'(bus.act_sel), 0);
        chk({tag, ".y_addr"},    int'(bus.y_addr), 0);
        chk({tag, ".busy"},      int'(busy), 0);
        chk({tag, ".done"},      int'(done), 0);
        chk({tag, ".err"},       int'(err), 0);
    endtask

    // One inference: start at cycle 0, compare every cycle until the cycle after done.
    task automatic run_vec(input vec_t v, input string tag);
        int    cyc;
        int    stalls;
        int    done_cyc;
        bit    rdy;
        beat_t b;
        build_model(v);
        @(negedge clk);
        set_cfg(v);
        start = 1'b1;
        bus.mac_ready = 1'b1;
        bus.act_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; stalls = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 3000) begin
            cyc_g = cyc;
            if (cyc == 1) begin
                chk({tag, ".load_busy"}, int'(busy), 1);
                chk({tag, ".load_mac_valid"}, int'(bus.mac_valid), 0);
                chk({tag, ".load_act_valid"}, int'(bus.act_valid), 0);
                chk({tag, ".load_err"}, int'(err), 0);
            end else if (q.size() > 0) begin
                b = q[0];
                chk({tag, ".busy"}, int'(busy), 1);
                chk({tag, ".done_early"}, int'(done), 0);
                chk({tag, ".err_run"}, int'(err), 0);
                chk({tag, ".mac_valid"}, int'(bus.mac_valid), int'(!b.is_act));
                chk({tag, ".act_valid"}, int'(bus.act_valid), int'(b.is_act));
                if (b.is_act) begin
                    chk({tag, ".act_sel"}, int'(bus.act_sel), int'(b.sel));
                    chk({tag, ".y_addr"}, int'(bus.y_addr), int'(b.addr));
                end else begin
                    chk({tag, ".w_addr"}, int'(bus.w_addr), int'(b.w));
                    chk({tag, ".x_addr"}, int'(bus.x_addr), int'(b.addr));
                    chk({tag, ".mac_first"}, int'(bus.mac_first), int'(b.first));
                    chk({tag, ".mac_last"}, int'(bus.mac_last), int'(b.last));
                end
            end else begin
                chk({tag, ".done"}, int'(done), 1);
                chk({tag, ".done_busy"}, int'(busy), 1);
                chk({tag, ".done_err"}, int'(err), int'(m_err));
                chk({tag, ".done_mac_valid"}, int'(bus.mac_valid), 0);
                chk({tag, ".done_act_valid"}, int'(bus.act_valid), 0);
                done_cyc = cyc;
            end
            case (v.mode)
                2'd0: begin bus.mac_ready = 1'b1; bus.act_ready = 1'b1; end
                2'd1: begin bus.mac_ready = 1'(cyc % 2); bus.act_ready = 1'b1; end
                default: begin
                    bus.mac_ready = ($urandom_range(0, 3) != 0);
                    bus.act_ready = ($urandom_range(0, 3) != 0);
                end
            endcase
            if (cyc >= 2 && q.size() > 0) begin
                rdy = q[0].is_act ? bus.act_ready : bus.mac_ready;
                if (rdy) void'(q.pop_front());
                else stalls++;
            end
            scramble_cfg();
            start = (v.poke && done_cyc < 0) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            cyc++;
        end
        cyc_g = cyc;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout no done within %0d cycles", tag, cyc);
        end else begin
            chk({tag, ".post_busy"}, int'(busy), 0);
            chk({tag, ".post_done"}, int'(done), 0);
            chk({tag, ".err_sticky"}, int'(err), int'(m_err));
            chk({tag, ".latency"}, done_cyc, 2 + m_sum + stalls);
            if (v.use_exp) chk({tag, ".done_cycle"}, done_cyc, int'(v.exp_done));
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t rv;
        rst = 1'b1; start = 1'b0;
        bus.mac_ready = 1'b0; bus.act_ready = 1'b0;
        set_cfg('0);

        //             nl  n1 n2 n3 n4 n5 a2 a3 a4 a5 md pk ue exp er
        tbl[0] = mk(3,  3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0);   // nominal
        tbl[1] = mk(3,  3, 2, 1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0);    // backpressure
        tbl[2] = mk(1,  3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);    // too few layers
        tbl[3] = mk(3,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);    // empty layer
        tbl[4] = mk(7,  2, 2, 2, 2, 2, 1, 2, 3, 1, 0, 0, 1, 26, 0);   // saturation
        tbl[5] = mk(4,  2, 3, 1, 2, 0, 3, 1, 2, 0, 0, 0, 1, 19, 0);   // nl5 beyond depth
        tbl[6] = mk(0,  1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 1);    // zero layers
        tbl[7] = mk(5, 20, 20, 20, 20, 20, 1, 1, 1, 1, 0, 0, 1, 1682, 0); // w_addr wrap
        tbl[8] = mk(3,  3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 13, 0);   // start while busy
        tbl[9] = mk(2,  1, 1, 0, 0, 0, 2, 0, 0, 0, 2, 1, 0, 0, 0);    // minimal, random ready

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // rst and start together: reset wins, sequencer stays idle.
        set_cfg(tbl[0]);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk_all_zero("rst_start");
        @(negedge clk);
        chk("rst_start.idle_busy", int'(busy), 0);

        for (int t = 0; t < 10; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        // Reset during layer-3 MAC, then a fresh run must be unaffected.
        @(negedge clk);
        set_cfg(tbl[0]);
        start = 1'b1; bus.mac_ready = 1'b1; bus.act_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cyc_g = 10;
        chk("midrst.pre_mac_valid", int'(bus.mac_valid), 1);
        chk("midrst.pre_w_addr", int'(bus.w_addr), 6);
        chk("midrst.pre_x_addr", int'(bus.x_addr), 7'h40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc_g = 11;
        chk_all_zero("midrst");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("midrst.no_done", int'(done), 0);
            chk("midrst.idle", int'(busy), 0);
        end
        run_vec(tbl[0], "after_rst");

        // Randomized configurations against the reference model.
        for (int r = 0; r < 25; r++) begin
            rv = '0;
            rv.no_layers = 6'($urandom_range(0, 7));
            for (int j = 0; j < 5; j++) begin
                rv.nl[j]  = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 4));
                rv.afl[j] = 2'($urandom);
            end
            rv.mode = 2'($urandom_range(0, 2));
            rv.poke = 1'($urandom);
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
